// File: rtl/d_jump_resolve_btb.sv
// Decode-stage control-transfer resolver with a direct-mapped BTB of
// 2-bit saturating counters and a held valid/ready redirect to Fetch.
//
// Optional build macro: D_JUMP_PERF_CNT_EN adds live perf_ctl / perf_misp
// counters; without it both ports read 0 and no counter flops exist.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   pc_f              fetch PC used for the combinational BTB lookup
//   pred_taken_f      entry valid & tag hit & counter MSB
//   pred_target_f     target stored in the looked-up entry
//   valid_d, stall_d  Decode holds an instruction / is stalled
//   pc_d              Decode PC
//   pred_taken_d      prediction carried down from Fetch
//   pred_target_d     predicted target carried down from Fetch
//   is_branch, br_cond  conditional branch and its outcome
//   j, jal, jr        unconditional transfers
//   target_d          resolved taken target
//   redirect_valid    redirect request to Fetch (held until accepted)
//   redirect_pc       redirect address (stable while pending)
//   redirect_ready    Fetch accepts the redirect
//   flush_f           valid & ready, one cycle on acceptance
//   hold_d            Decode hold while a redirect is pending
//   perf_ctl          resolved control instructions
//   perf_misp         mispredicts that raised a redirect
module d_jump_resolve_btb #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned BTB_DEPTH  = 16,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [PC_W-1:0] pred_target_f,
    input  logic            valid_d,
    input  logic            stall_d,
    input  logic [PC_W-1:0] pc_d,
    input  logic            pred_taken_d,
    input  logic [PC_W-1:0] pred_target_d,
    input  logic            is_branch,
    input  logic            br_cond,
    input  logic            j,
    input  logic            jal,
    input  logic            jr,
    input  logic [PC_W-1:0] target_d,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush_f,
    output logic            hold_d,
    output logic [31:0]     perf_ctl,
    output logic [31:0]     perf_misp
);

    localparam int unsigned IDX_W  = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W  = PC_W - IDX_W - 2;
    localparam int unsigned FT_OFS = (DELAY_SLOT != 0) ? 8 : 4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    // BTB storage: valid/ctr are reset, tag/target are plain data
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [1:0]           btb_ctr [BTB_DEPTH];
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [PC_W-1:0]      btb_tgt [BTB_DEPTH];

    logic [IDX_W-1:0] idx_f, idx_d;
    logic [TAG_W-1:0] tag_f, tag_d;

    logic            res, ctl, jump, act_taken, pred_ok;
    logic            misp, hit_d, wr_en, inv_en, load_redir;
    logic [PC_W-1:0] ft, misp_pc;
    logic [1:0]      cur_ctr, new_ctr;

    // Word-aligned PCs: the low two bits never take part in indexing
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], pc_d[1:0]};

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[PC_W-1:IDX_W+2];
    assign idx_d = pc_d[IDX_W+1:2];
    assign tag_d = pc_d[PC_W-1:IDX_W+2];

    // Fetch lookup sees pre-write contents on a same-index D write
    assign pred_taken_f  = btb_valid[idx_f] & (btb_tag[idx_f] == tag_f) & btb_ctr[idx_f][1];
    assign pred_target_f = btb_tgt[idx_f];

    assign hold_d         = (state_q == PEND);
    assign redirect_valid = (state_q == PEND);
    assign flush_f        = redirect_valid & redirect_ready;

    assign res       = valid_d & ~stall_d & ~hold_d;
    assign jump      = j | jal | jr;
    assign ctl       = is_branch | jump;
    assign act_taken = jump | (is_branch & br_cond);
    assign ft        = pc_d + PC_W'(FT_OFS);
    assign pred_ok   = pred_taken_d & (pred_target_d == target_d);

    // Mispredict detection and redirect address
    always_comb begin
        misp    = 1'b0;
        misp_pc = '0;
        if (act_taken && !pred_ok) begin
            misp    = 1'b1;
            misp_pc = target_d;
        end else if (!act_taken && pred_taken_d) begin
            misp    = 1'b1;
            misp_pc = ft;
        end
    end

    // Training: saturating update on tag hit, type-based seed on miss
    always_comb begin
        cur_ctr = btb_ctr[idx_d];
        hit_d   = btb_valid[idx_d] & (btb_tag[idx_d] == tag_d);
        new_ctr = 2'd0;
        if (hit_d) begin
            if (act_taken) new_ctr = (cur_ctr == 2'd3) ? 2'd3 : 2'(cur_ctr + 2'd1);
            else           new_ctr = (cur_ctr == 2'd0) ? 2'd0 : 2'(cur_ctr - 2'd1);
        end else begin
            if (jump)           new_ctr = 2'd3;
            else if (act_taken) new_ctr = 2'd2;
            else                new_ctr = 2'd1;
        end
        wr_en  = res & ctl;
        inv_en = res & ~ctl & pred_taken_d;
    end

    // BTB valid bits and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid <= '0;
            for (int i = 0; i < int'(BTB_DEPTH); i++) btb_ctr[i] <= 2'd0;
        end else if (wr_en) begin
            btb_valid[idx_d] <= 1'b1;
            btb_ctr[idx_d]   <= new_ctr;
        end else if (inv_en) begin
            btb_valid[idx_d] <= 1'b0;
        end
    end

    // BTB tag and target payload
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag[idx_d] <= tag_d;
            btb_tgt[idx_d] <= target_d;
        end
    end

    // Redirect FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Redirect FSM next-state
    always_comb begin
        state_d    = state_q;
        load_redir = 1'b0;
        case (state_q)
            IDLE: if (res && misp) begin
                state_d    = PEND;
                load_redir = 1'b1;
            end
            PEND: if (redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Redirect address, captured on the resolve edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           redirect_pc <= '0;
        else if (load_redir) redirect_pc <= misp_pc;
    end

`ifdef D_JUMP_PERF_CNT_EN
    logic [31:0] ctl_cnt_q, misp_cnt_q;

    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_cnt_q  <= '0;
            misp_cnt_q <= '0;
        end else begin
            if (wr_en)      ctl_cnt_q  <= 32'(ctl_cnt_q + 32'd1);
            if (load_redir) misp_cnt_q <= 32'(misp_cnt_q + 32'd1);
        end
    end

    assign perf_ctl  = ctl_cnt_q;
    assign perf_misp = misp_cnt_q;
`else
    assign perf_ctl  = '0;
    assign perf_misp = '0;
`endif

endmodule

// File: tb/tb_d_jump_resolve_btb.sv
// Directed bench for d_jump_resolve_btb (PC_W=32, BTB_DEPTH=16, DELAY_SLOT=1).
module tb_d_jump_resolve_btb;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_JR   = 5'b00001;
    localparam logic [4:0] F_JAL  = 5'b00010;
    localparam logic [4:0] F_J    = 5'b00100;
    localparam logic [4:0] F_BN   = 5'b10000;
    localparam logic [4:0] F_BT   = 5'b11000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f, pc_d, pred_target_d, target_d;
    logic        valid_d, stall_d, pred_taken_d, is_branch, br_cond, j, jal, jr;
    logic        redirect_ready;
    logic        pred_taken_f, redirect_valid, flush_f, hold_d;
    logic [31:0] pred_target_f, redirect_pc, perf_ctl, perf_misp;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ctl, exp_misp;

    d_jump_resolve_btb #(.PC_W(32), .BTB_DEPTH(16), .DELAY_SLOT(1)) dut (
        .clk(clk), .reset(reset), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .valid_d(valid_d), .stall_d(stall_d), .pc_d(pc_d),
        .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
        .is_branch(is_branch), .br_cond(br_cond), .j(j), .jal(jal), .jr(jr),
        .target_d(target_d), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .flush_f(flush_f), .hold_d(hold_d),
        .perf_ctl(perf_ctl), .perf_misp(perf_misp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_d();
        valid_d = 0; stall_d = 0; pc_d = 0; pred_taken_d = 0; pred_target_d = 0;
        is_branch = 0; br_cond = 0; j = 0; jal = 0; jr = 0; target_d = 0;
    endtask

    // One resolve cycle; returns #1 after the following negedge
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt, input logic [4:0] fl);
        pc_d = pc; target_d = tgt; pred_taken_d = pt; pred_target_d = ptgt;
        is_branch = fl[4]; br_cond = fl[3]; j = fl[2]; jal = fl[1]; jr = fl[0];
        valid_d = 1;
        @(negedge clk);
        clear_d();
        #1;
    endtask

    task automatic accept();
        redirect_ready = 1;
        #1;
        chk("flush_on_accept", flush_f, 1);
        @(negedge clk);
        redirect_ready = 0;
        #1;
        chk("idle_after_accept", redirect_valid, 0);
        chk("hold_released", hold_d, 0);
        chk("flush_single_pulse", flush_f, 0);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic expt, input string tag);
        pc_f = pc;
        #1;
        chk(tag, pred_taken_f, expt);
    endtask

    initial begin
        clear_d();
        pc_f = 0; redirect_ready = 0; reset = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_hold", hold_d, 0);
        chk("rst_flush", flush_f, 0);
        chk("rst_pred_taken", pred_taken_f, 0);
        @(negedge clk);
        reset = 0;
        #1;

        // Cold jal mispredicts, trains entry 0
        lookup(32'h3000, 0, "pred_cold");
        resolve(32'h3000, 32'h3400, 0, 0, F_JAL);
        chk("jal_redirect_valid", redirect_valid, 1);
        chk("jal_redirect_pc", redirect_pc, 32'h3400);
        chk("jal_hold", hold_d, 1);
        chk("jal_no_flush_yet", flush_f, 0);
        chk("jal_trained_taken", pred_taken_f, 1);
        chk("jal_trained_target", pred_target_f, 32'h3400);
        accept();

        // Branch trained taken three times: ctr 2 -> 3 -> 3
        resolve(32'h3010, 32'h3100, 0, 0, F_BT);
        chk("br1_redirect_pc", redirect_pc, 32'h3100);
        accept();
        resolve(32'h3010, 32'h3100, 1, 32'h3100, F_BT);
        chk("br2_no_redirect", redirect_valid, 0);
        resolve(32'h3010, 32'h3100, 1, 32'h3100, F_BT);
        chk("br3_no_redirect", redirect_valid, 0);
        lookup(32'h3010, 1, "br_ctr_sat");

        // Not taken but predicted: redirect to pc+8, ctr 3 -> 2
        resolve(32'h3010, 32'h3100, 1, 32'h3100, F_BN);
        chk("bn_redirect_valid", redirect_valid, 1);
        chk("bn_redirect_pc_ft", redirect_pc, 32'h3018);

        // Ready low for 4 cycles; resolves presented meanwhile are ignored
        for (int i = 0; i < 4; i++) begin
            pc_d = 32'h3030; target_d = 32'h3F00; j = 1; valid_d = 1;
            @(negedge clk);
            #1;
            chk("pend_valid_held", redirect_valid, 1);
            chk("pend_pc_stable", redirect_pc, 32'h3018);
            chk("pend_hold", hold_d, 1);
            chk("pend_no_flush", flush_f, 0);
        end
        clear_d();
        lookup(32'h3010, 1, "br_ctr_dec_to_2");
        accept();
        lookup(32'h3030, 0, "pend_resolve_not_trained");

        // Second not-taken: ctr 2 -> 1 drops the prediction
        resolve(32'h3010, 32'h3100, 1, 32'h3100, F_BN);
        chk("bn2_redirect_pc_ft", redirect_pc, 32'h3018);
        accept();
        lookup(32'h3010, 0, "br_ctr_dec_to_1");

        // Correct predictions: no redirect, counters advance
        resolve(32'h3000, 32'h3400, 1, 32'h3400, F_JAL);
        chk("ok_jal_no_redirect", redirect_valid, 0);
        chk("ok_jal_no_flush", flush_f, 0);
        chk("ok_jal_no_hold", hold_d, 0);
        lookup(32'h3000, 1, "ok_jal_still_pred");
        resolve(32'h3010, 32'h3100, 1, 32'h3100, F_BT);
        chk("ok_br_no_redirect", redirect_valid, 0);
        lookup(32'h3010, 1, "br_ctr_inc_to_2");

        // Train idx 8, then alias with a non-control instruction
        resolve(32'h3020, 32'h3200, 0, 0, F_J);
        chk("j_redirect_pc", redirect_pc, 32'h3200);
        accept();
        pc_f = 32'h3020; pc_d = 32'h3020; pred_taken_d = 1; pred_target_d = 32'h3200;
        valid_d = 1;
        #1;
        chk("same_cycle_old_taken", pred_taken_f, 1);
        chk("same_cycle_old_target", pred_target_f, 32'h3200);
        @(negedge clk);
        clear_d();
        #1;
        chk("alias_redirect_valid", redirect_valid, 1);
        chk("alias_redirect_pc", redirect_pc, 32'h3028);
        chk("alias_invalidated", pred_taken_f, 0);
        accept();

        // Cold not-taken branch: no redirect, weak not-taken seed
        resolve(32'h3040, 32'h3080, 0, 0, F_BN);
        chk("bn_cold_no_redirect", redirect_valid, 0);
        lookup(32'h3040, 0, "bn_cold_seed");

        // Multiple jump flags act as one transfer to target_d
        resolve(32'h3050, 32'h3500, 0, 0, F_J | F_JAL);
        chk("multi_redirect_pc", redirect_pc, 32'h3500);
        accept();
        lookup(32'h3050, 1, "multi_trained");

        // Stalled decode does not resolve
        pc_d = 32'h3070; target_d = 32'h3700; j = 1; valid_d = 1; stall_d = 1;
        @(negedge clk);
        clear_d();
        #1;
        chk("stall_no_redirect", redirect_valid, 0);
        lookup(32'h3070, 0, "stall_not_trained");

`ifdef D_JUMP_PERF_CNT_EN
        exp_ctl = 32'd11; exp_misp = 32'd7;
`else
        exp_ctl = 32'd0;  exp_misp = 32'd0;
`endif
        chk("perf_ctl", perf_ctl, exp_ctl);
        chk("perf_misp", perf_misp, exp_misp);

        // Reset while a redirect is pending
        resolve(32'h3060, 32'h3600, 0, 0, F_JR);
        chk("jr_pending", redirect_valid, 1);
        pc_f = 32'h3000;
        reset = 1;
        #1;
        chk("rst_pend_valid", redirect_valid, 0);
        chk("rst_pend_hold", hold_d, 0);
        chk("rst_pend_pc", redirect_pc, 0);
        chk("rst_pend_flush", flush_f, 0);
        chk("rst_btb_cleared", pred_taken_f, 0);
        chk("rst_perf_ctl", perf_ctl, 0);
        chk("rst_perf_misp", perf_misp, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        #1;
        chk("post_rst_dropped", redirect_valid, 0);
        chk("post_rst_btb_empty", pred_taken_f, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_jump_resolve_btb.md
Name: d_jump_resolve_btb

Overview:
- Parametrised Decode-stage control-transfer resolver with a small branch target buffer (BTB) of 2-bit saturating counters.
- Fetch reads a prediction for pc_f. Decode resolves j/jal/jr/conditional branches against the prediction carried down the IF/ID register.
- On a mispredict, a registered redirect is issued to Fetch through a valid/ready handshake, and the BTB is trained.
- Replaces the plain OR-of-jump-flags indication with prediction, training and held redirects.

Parameters:
- PC_W, 32, PC width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of 2, at least 2. IDX_W = log2(BTB_DEPTH).
- DELAY_SLOT, 1, if 1, fall-through address is pc_d+8; if 0, pc_d+4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pc_f  in  PC_W  fetch PC for BTB lookup
- pred_taken_f  out  1  Fetch prediction: entry valid & tag match & ctr[1]
- pred_target_f  out  PC_W  predicted target (entry target; don't-care when pred_taken_f=0)
- valid_d  in  1  Decode holds a valid instruction
- stall_d  in  1  Decode stalled by hazard logic; no resolution this cycle
- pc_d  in  PC_W  Decode PC
- pred_taken_d  in  1  prediction carried from F
- pred_target_d  in  PC_W  predicted target carried from F
- is_branch  in  1  conditional branch in D
- br_cond  in  1  branch condition result
- j  in  1  unconditional jump
- jal  in  1  jump-and-link
- jr  in  1  register jump
- target_d  in  PC_W  resolved taken target
- redirect_valid  out  1  redirect request to Fetch
- redirect_pc  out  PC_W  redirect address
- redirect_ready  in  1  Fetch accepts redirect
- flush_f  out  1  one-cycle pulse when a redirect is accepted
- hold_d  out  1  stalls Decode while a redirect is pending

Behaviour:
- Address mapping: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- BTB entry: {valid, tag, target, ctr[1:0]}. The read is combinational on pc_f.
- Resolve event: res = valid_d & ~stall_d & ~hold_d. Inputs are ignored when res=0.
- ctl = is_branch|j|jal|jr. act_taken = j|jal|jr|(is_branch&br_cond). ft = pc_d + (DELAY_SLOT?8:4).
- Mispredict:
  - act_taken & ~(pred_taken_d & pred_target_d==target_d): redirect to target_d.
  - ~act_taken & pred_taken_d: redirect to ft.
  - Otherwise no redirect.
- FSM IDLE/PEND:
  - IDLE: res & mispredict -> PEND next cycle, with redirect_valid=1 and redirect_pc registered.
  - PEND: redirect_valid stays high and redirect_pc stays stable until redirect_ready. On the accept cycle, flush_f=1 (combinational valid&ready) and the FSM returns to IDLE next cycle.
  - hold_d=1 whenever in PEND.
- Redirect latency: exactly 1 cycle from the resolve edge to redirect_valid.
- Training on res (write at clock edge):
  - ctl: write valid=1, tag, target=target_d.
    - Tag hit: ctr saturating increment if act_taken, else decrement. Bounds are 0 and 3; no wrap.
    - Tag miss: ctr=3 for j/jal/jr, 2 for taken branch, 1 for not-taken branch.
  - ~ctl & pred_taken_d: clear the valid bit of that idx (aliasing invalidation).
  - ~ctl & ~pred_taken_d: no write.
- Simultaneous F read and D write to the same idx: F sees the pre-write contents.
- Reset (asynchronous, any state including PEND):
  - All valid bits and counters -> 0; FSM -> IDLE.
  - redirect_valid=0, redirect_pc=0, flush_f=0, hold_d=0, pred_taken_f=0.
  - A pending redirect is dropped.
- Multiple jump flags asserted together: treated as one unconditional transfer to target_d.

Optional Feature:
- Macro: D_JUMP_PERF_CNT_EN.
- Defined: adds outputs perf_ctl[31:0] (resolves with ctl=1) and perf_misp[31:0] (accepted mispredicts, i.e. IDLE->PEND transitions).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: both ports are present but tied to 0, and no counter flops are built.

Test Plan:
- Reset, then pc_f=0x3000 -> pred_taken_f=0. Resolve jal at pc_d=0x3000, target_d=0x3400, pred_taken_d=0 -> next cycle redirect_valid=1, redirect_pc=0x3400, hold_d=1. Afterwards pc_f=0x3000 -> pred_taken_f=1, pred_target_f=0x3400.
- Branch at pc 0x3010, target 0x3100, resolved taken 3 times -> ctr reaches 3 and saturates. Then not taken with pred_taken_d=1 -> redirect_pc=0x3018 (DELAY_SLOT=1) and ctr=2.
- redirect_ready held low 4 cycles after a mispredict -> redirect_valid and redirect_pc stable, hold_d=1 throughout, and new resolves are ignored. ready=1 -> flush_f pulses for 1 cycle, then IDLE.
- Correct prediction (pred_taken_d=1, pred_target_d==target_d=0x3400) -> no redirect, flush_f stays 0, and the counter is incremented.
- Non-control instruction with pred_taken_d=1 at pc 0x3020 -> redirect to 0x3028 and the entry is invalidated. A same-cycle read of that idx via pc_f returns the old (valid) entry.
- Assert reset while in PEND -> redirect_valid drops immediately, the BTB is cleared, and with D_JUMP_PERF_CNT_EN defined perf_ctl=perf_misp=0.
